// File: rtl/video_pkg.sv
// Shared definitions for the video memory path: read-arbiter FSM states,
// default burst limit and burst-length normalisation.
package video_pkg;

  localparam int BURST_MAX_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DATA  = 2'd2
  } arb_state_e;

  // Zero-length bursts become single beats; oversize bursts are capped.
  function automatic logic [31:0] clamp_burst(input logic [31:0] bc,
                                              input logic [31:0] max_beats);
    logic [31:0] res;
    if (bc == 32'd0) begin
      res = 32'd1;
    end else if (bc > max_beats) begin
      res = max_beats;
    end else begin
      res = bc;
    end
    return res;
  endfunction

endpackage

// File: rtl/avalon_read_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes to
// the requester that was not served last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // One-hot grant from the request pair and the previous winner.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/avalon_read_arbiter.sv
// Two-requester Avalon-MM burst read arbiter in front of the shared SDRAM
// host port; one burst in flight at a time.
module avalon_read_arbiter
  import video_pkg::*;
#(
  parameter int  ADDR_W    = 32,
  parameter int  DATA_W    = 32,
  parameter int  BURST_MAX = BURST_MAX_DEFAULT,
  localparam int BC_W      = $clog2(BURST_MAX) + 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [1:0]          m_read,
  input  logic [2*ADDR_W-1:0] m_address,
  input  logic [2*BC_W-1:0]   m_burstcount,
  output logic [1:0]          m_waitrequest,
  output logic [DATA_W-1:0]   m_readdata,
  output logic [1:0]          m_readdatavalid,
  output logic                h_read,
  output logic [ADDR_W-1:0]   h_address,
  output logic [BC_W-1:0]     h_burstcount,
  input  logic                h_waitrequest,
  input  logic [DATA_W-1:0]   h_readdata,
  input  logic                h_readdatavalid,
  output logic                err_stray
);

  localparam logic [BC_W-1:0] ONE_BEAT = {{(BC_W-1){1'b0}}, 1'b1};

  arb_state_e        state_r;
  logic              grant_r;
  logic              last_grant_r;
  logic              err_stray_r;
  logic [ADDR_W-1:0] addr_r;
  logic [BC_W-1:0]   bc_r;
  logic [BC_W-1:0]   beat_cnt_r;

  logic [1:0]        gnt_s;
  logic              gnt_idx_s;
  logic [ADDR_W-1:0] addr_sel_s;
  logic [BC_W-1:0]   bc_raw_s;
  logic [BC_W-1:0]   bc_sel_s;
  logic [1:0]        wait_s;
  logic [1:0]        valid_s;

  rr_pick2 u_rr_pick2 (
    .req  (m_read),
    .last (last_grant_r),
    .gnt  (gnt_s)
  );

  // Command of the requester picked this cycle, burst length normalised.
  always_comb begin
    gnt_idx_s  = gnt_s[1] & ~gnt_s[0];
    addr_sel_s = m_address[ADDR_W-1:0];
    bc_raw_s   = m_burstcount[BC_W-1:0];
    if (gnt_idx_s) begin
      addr_sel_s = m_address[2*ADDR_W-1:ADDR_W];
      bc_raw_s   = m_burstcount[2*BC_W-1:BC_W];
    end else begin
      addr_sel_s = m_address[ADDR_W-1:0];
      bc_raw_s   = m_burstcount[BC_W-1:0];
    end
    bc_sel_s = BC_W'(clamp_burst(32'(bc_raw_s), 32'(BURST_MAX)));
  end

  // Arbitration FSM, latched command, beat counter and sticky stray flag.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r      <= ST_IDLE;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
      addr_r       <= '0;
      bc_r         <= '0;
      beat_cnt_r   <= '0;
      err_stray_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|m_read) begin
            grant_r <= gnt_idx_s;
            addr_r  <= addr_sel_s;
            bc_r    <= bc_sel_s;
            state_r <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!h_waitrequest) begin
            beat_cnt_r <= bc_r;
            state_r    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (h_readdatavalid) begin
            beat_cnt_r <= beat_cnt_r - ONE_BEAT;
            if (beat_cnt_r == ONE_BEAT) begin
              last_grant_r <= grant_r;
              state_r      <= ST_IDLE;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
      // A beat with no burst in flight is dropped and remembered.
      if (h_readdatavalid && (state_r != ST_DATA)) begin
        err_stray_r <= 1'b1;
      end
    end
  end

  // Acceptance handshake and data strobe routed to the granted requester.
  always_comb begin
    wait_s  = 2'b11;
    valid_s = 2'b00;
    if ((state_r == ST_ISSUE) && !h_waitrequest) begin
      wait_s[grant_r] = 1'b0;
    end else begin
      wait_s = 2'b11;
    end
    if (state_r == ST_DATA) begin
      valid_s[grant_r] = h_readdatavalid;
    end else begin
      valid_s = 2'b00;
    end
  end

  assign m_waitrequest   = wait_s;
  assign m_readdatavalid = valid_s;
  assign m_readdata      = h_readdata;
  assign h_read          = (state_r == ST_ISSUE);
  assign h_address       = addr_r;
  assign h_burstcount    = bc_r;
  assign err_stray       = err_stray_r;

endmodule

// File: tb/tb_avalon_read_arbiter.sv
// Bench for avalon_read_arbiter: transaction-level reference (pending command,
// beats remaining, last owner) checked every cycle, plus directed scenarios.
module tb_avalon_read_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BM  = 16;
  localparam int BCW = 5;

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b1;
  logic [1:0]      m_read;
  logic [2*AW-1:0] m_address;
  logic [2*BCW-1:0] m_burstcount;
  logic [1:0]      m_waitrequest;
  logic [DW-1:0]   m_readdata;
  logic [1:0]      m_readdatavalid;
  logic            h_read;
  logic [AW-1:0]   h_address;
  logic [BCW-1:0]  h_burstcount;
  logic            h_waitrequest;
  logic [DW-1:0]   h_readdata;
  logic            h_readdatavalid;
  logic            err_stray;

  avalon_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m_read(m_read), .m_address(m_address), .m_burstcount(m_burstcount),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .h_read(h_read), .h_address(h_address), .h_burstcount(h_burstcount),
    .h_waitrequest(h_waitrequest), .h_readdata(h_readdata),
    .h_readdatavalid(h_readdatavalid), .err_stray(err_stray)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference: a command is either waiting for the host, or N beats are owed.
  logic          mdl_pend;
  int            mdl_beats;
  int            mdl_owner;
  int            mdl_last;
  logic [AW-1:0] mdl_addr;
  int            mdl_bc;
  logic          mdl_err;

  function automatic int pick_owner(input logic [1:0] req, input int last);
    if (req == 2'b11) return 1 - last;
    else if (req[1]) return 1;
    else return 0;
  endfunction

  function automatic int norm_bc(input int raw);
    if (raw == 0) return 1;
    else if (raw > BM) return BM;
    else return raw;
  endfunction

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mdl_pend <= 1'b0; mdl_beats <= 0; mdl_owner <= 0; mdl_last <= 1;
      mdl_addr <= '0; mdl_bc <= 0; mdl_err <= 1'b0;
    end else if (mdl_pend) begin
      if (h_readdatavalid) mdl_err <= 1'b1;
      if (!h_waitrequest) begin
        mdl_pend  <= 1'b0;
        mdl_beats <= mdl_bc;
      end
    end else if (mdl_beats > 0) begin
      if (h_readdatavalid) begin
        mdl_beats <= mdl_beats - 1;
        if (mdl_beats == 1) mdl_last <= mdl_owner;
      end
    end else begin
      if (h_readdatavalid) mdl_err <= 1'b1;
      if (m_read != 2'b00) begin
        mdl_owner <= pick_owner(m_read, mdl_last);
        mdl_addr  <= (pick_owner(m_read, mdl_last) == 1) ? m_address[2*AW-1:AW] : m_address[AW-1:0];
        mdl_bc    <= norm_bc((pick_owner(m_read, mdl_last) == 1) ? int'(m_burstcount[2*BCW-1:BCW])
                                                                 : int'(m_burstcount[BCW-1:0]));
        mdl_pend  <= 1'b1;
      end
    end
  end

  // Host-side responder state and per-scenario statistics.
  int            host_q = 0;
  int            wait_hold = 0;
  int            wait_pct = 0;
  int            valid_pct = 100;
  logic          stray_pulse = 1'b0;
  logic          acc_seen = 1'b0;
  int            acc_bc = 0;
  logic [1:0]    acc_m = 2'b00;
  logic          hread_seen = 1'b0;
  logic          prev_hread = 1'b0;
  int            hread_cnt, addr_changes, wlow_bad;
  int            beats[2];
  int            wlow[2];
  int            last_beat[2];
  int            rise_cyc[$];
  logic [AW-1:0] rise_addr[$];
  int            rise_bc[$];
  logic [AW-1:0] cur_addr;
  logic [BCW-1:0] cur_bc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    hread_cnt = 0; addr_changes = 0; wlow_bad = 0;
    for (int i = 0; i < 2; i++) begin beats[i] = 0; wlow[i] = 0; last_beat[i] = -1; end
    rise_cyc.delete(); rise_addr.delete(); rise_bc.delete();
  endtask

  // Every-cycle comparison against the reference, plus statistics.
  task automatic monitor();
    logic [1:0] ew;
    logic [1:0] ev;
    cyc++;
    ew = 2'b11;
    if (mdl_pend && !h_waitrequest) ew[mdl_owner] = 1'b0;
    ev = 2'b00;
    if ((mdl_beats > 0) && h_readdatavalid) ev[mdl_owner] = 1'b1;
    check("h_read", 64'(h_read), 64'(mdl_pend));
    check("h_address", 64'(h_address), 64'(mdl_addr));
    check("h_burstcount", 64'(h_burstcount), 64'(mdl_bc));
    check("m_waitrequest", 64'(m_waitrequest), 64'(ew));
    check("m_readdatavalid", 64'(m_readdatavalid), 64'(ev));
    check("m_readdata", 64'(m_readdata), 64'(h_readdata));
    check("err_stray", 64'(err_stray), 64'(mdl_err));
    if (h_read) begin
      hread_cnt++;
      if (!prev_hread) begin
        rise_cyc.push_back(cyc); rise_addr.push_back(h_address); rise_bc.push_back(int'(h_burstcount));
      end else if ((h_address != cur_addr) || (h_burstcount != cur_bc)) begin
        addr_changes++;
      end
      cur_addr = h_address; cur_bc = h_burstcount;
    end
    prev_hread = h_read;
    for (int i = 0; i < 2; i++) begin
      if (m_readdatavalid[i]) begin beats[i]++; last_beat[i] = cyc; end
      if (!m_waitrequest[i]) begin wlow[i]++; if (h_waitrequest) wlow_bad++; end
    end
    acc_seen   = h_read && !h_waitrequest;
    acc_bc     = int'(h_burstcount);
    acc_m      = ~m_waitrequest;
    hread_seen = h_read;
  endtask

  // Host responder and requester drop-on-accept, applied just after the edge.
  task automatic drive();
    if (sys_rst) host_q = 0;
    else if (acc_seen) host_q += acc_bc;
    if (hread_seen && (wait_hold > 0)) wait_hold--;
    h_readdatavalid = 1'b0;
    if (stray_pulse) begin
      h_readdatavalid = 1'b1; stray_pulse = 1'b0;
    end else if ((host_q > 0) && (int'($urandom_range(99)) < valid_pct)) begin
      h_readdatavalid = 1'b1; host_q--;
    end
    h_waitrequest = (wait_hold > 0) ? 1'b1 : (int'($urandom_range(99)) < wait_pct);
    h_readdata = $urandom;
    for (int i = 0; i < 2; i++) if (acc_m[i]) m_read[i] = 1'b0;
  endtask

  task automatic tick();
    @(negedge sys_clk);
    monitor();
    @(posedge sys_clk);
    #1;
    drive();
  endtask

  task automatic reset_pulse();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] addr, input int bc);
    m_address[i*AW +: AW]     = addr;
    m_burstcount[i*BCW +: BCW] = BCW'(bc);
    m_read[i] = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_h_read"}, 64'(h_read), 64'd0);
    check({tag, "_h_address"}, 64'(h_address), 64'd0);
    check({tag, "_h_burstcount"}, 64'(h_burstcount), 64'd0);
    check({tag, "_m_waitrequest"}, 64'(m_waitrequest), 64'd3);
    check({tag, "_m_readdatavalid"}, 64'(m_readdatavalid), 64'd0);
    check({tag, "_err_stray"}, 64'(err_stray), 64'd0);
  endtask

  initial begin
    m_read = 2'b00; m_address = '0; m_burstcount = '0;
    h_waitrequest = 1'b0; h_readdata = '0; h_readdatavalid = 1'b0;
    clear_stats();
    repeat (2) tick();
    check_reset_values("reset");
    sys_rst = 1'b0;
    tick();

    // Single requester, 16-beat burst, host never stalls.
    clear_stats();
    set_req(0, 32'h0000_0100, 16);
    repeat (30) tick();
    check("t1_hread_cycles", 64'(hread_cnt), 64'd1);
    check("t1_addr", 64'(rise_addr.size() > 0 ? rise_addr[0] : 32'hdead), 64'h100);
    check("t1_bc", 64'(rise_bc.size() > 0 ? rise_bc[0] : 99), 64'd16);
    check("t1_beats0", 64'(beats[0]), 64'd16);
    check("t1_beats1", 64'(beats[1]), 64'd0);

    // Simultaneous requests after reset: req0 first, req1 two cycles after.
    reset_pulse();
    clear_stats();
    set_req(0, 32'h0000_0200, 3);
    set_req(1, 32'h0000_4000, 4);
    repeat (40) tick();
    check("t2_bursts", 64'(rise_cyc.size()), 64'd2);
    if (rise_cyc.size() == 2) begin
      check("t2_first_addr", 64'(rise_addr[0]), 64'h200);
      check("t2_second_addr", 64'(rise_addr[1]), 64'h4000);
      check("t2_second_bc", 64'(rise_bc[1]), 64'd4);
      check("t2_gap", 64'(rise_cyc[1] - last_beat[0]), 64'd2);
    end
    check("t2_beats0", 64'(beats[0]), 64'd3);
    check("t2_beats1", 64'(beats[1]), 64'd4);

    // Host stalls five cycles in ISSUE.
    clear_stats();
    wait_hold = 5;
    set_req(1, 32'h0000_0880, 2);
    repeat (20) tick();
    check("t3_hread_cycles", 64'(hread_cnt), 64'd6);
    check("t3_cmd_stable", 64'(addr_changes), 64'd0);
    check("t3_wlow1", 64'(wlow[1]), 64'd1);
    check("t3_wlow0", 64'(wlow[0]), 64'd0);
    check("t3_wlow_stalled", 64'(wlow_bad), 64'd0);
    check("t3_beats1", 64'(beats[1]), 64'd2);

    // Burst length normalisation.
    clear_stats();
    set_req(0, 32'h0000_0010, 0);
    repeat (10) tick();
    check("t4_bc0", 64'(rise_bc.size() > 0 ? rise_bc[0] : 99), 64'd1);
    check("t4_bc0_beats", 64'(beats[0]), 64'd1);
    clear_stats();
    set_req(1, 32'h0000_0020, 31);
    repeat (30) tick();
    check("t4_bc31", 64'(rise_bc.size() > 0 ? rise_bc[0] : 99), 64'd16);
    check("t4_bc31_beats", 64'(beats[1]), 64'd16);

    // Stray beat in IDLE is dropped and the flag sticks.
    clear_stats();
    stray_pulse = 1'b1;
    repeat (3) tick();
    check("t5_no_forward", 64'(beats[0] + beats[1]), 64'd0);
    check("t5_err_set", 64'(err_stray), 64'd1);
    set_req(0, 32'h0000_0040, 2);
    repeat (12) tick();
    check("t5_beats_after", 64'(beats[0]), 64'd2);
    check("t5_err_sticky", 64'(err_stray), 64'd1);

    // Reset after beat 7 of 16, then a tie goes to req0.
    reset_pulse();
    clear_stats();
    set_req(0, 32'h0000_0300, 16);
    for (int k = 0; k < 40 && beats[0] < 7; k++) tick();
    check("t6_reached_beat7", 64'(beats[0]), 64'd7);
    sys_rst = 1'b1;
    #1;
    check_reset_values("t6_midburst");
    set_req(0, 32'h0000_0600, 2);
    set_req(1, 32'h0000_0500, 2);
    tick();
    sys_rst = 1'b0;
    clear_stats();
    repeat (20) tick();
    check("t6_next_grant", 64'(rise_addr.size() > 0 ? rise_addr[0] : 32'hdead), 64'h600);
    check("t6_no_stray", 64'(err_stray), 64'd0);

    // Randomised traffic with stalls, gaps, dropped requests and resets.
    reset_pulse();
    wait_pct = 30;
    valid_pct = 70;
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (!m_read[i] && ($urandom_range(99) < 25))
          set_req(i, $urandom, int'($urandom_range(31)));
        else if (m_read[i] && ($urandom_range(99) < 2))
          m_read[i] = 1'b0;
      end
      if ($urandom_range(999) < 3) stray_pulse = 1'b1;
      if ($urandom_range(999) < 5) reset_pulse();
    end
    m_read = 2'b00;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
